seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised multi-cycle unsigned restoring divider that succeeds the fixed 16/16→8 binary divider. It accepts a single-cycle `enable` start pulse and produces one dividend bit per cycle. It returns a saturating quotient, a remainder, and status flags with a one-cycle `done` pulse. It sits in the same datapath as its predecessor, e.g. computing normalised ratios of accumulated counts, and is sized per instance.

## Interface
- `N_W`, 16, dividend width (≥2)
- `D_W`, 16, divisor and remainder width (≥1, ≤N_W)
- `Q_W`, 8, output quotient width (≥1, ≤N_W)
- `clk` in 1: single clock; all state on rising edge
- `reset_n` in 1: reset is asynchronous and active-low
- `enable` in 1: start request, sampled only in IDLE
- `g_dividend_Q` in N_W: dividend, captured on accepted start
- `g_divider_Q` in D_W: divisor, captured on accepted start
- `quotient` out Q_W: result, saturated to 2^Q_W−1
- `remainder` out D_W: dividend mod divisor (truncating division)
- `busy` out 1: high from cycle after accepted start until `done` cycle inclusive
- `done` out 1: one-cycle pulse, results valid
- `overflow` out 1: true quotient ≥ 2^Q_W
- `div_by_zero` out 1: captured divisor was 0

## Operation
- States: IDLE, CALC, ROUND (only with macro), DONE.
- IDLE: `enable`=1 captures the operands and clears the bit counter. Next state is CALC, or DONE directly if the divisor is 0.
- CALC: each cycle, the partial remainder (D_W+1 bits) is shifted left and takes the next dividend MSB. The divisor is subtracted if there is no borrow, and the quotient bit is shifted into the N_W-bit internal quotient. Runs exactly N_W cycles.
- Exit from CALC is to DONE, or to ROUND with the macro.
- DONE: output registers are loaded at entry. `done`=1 for one cycle, then the state returns to IDLE. Outputs hold their values until the next completion or reset.
- Saturation: if internal quotient bits above Q_W−1 are nonzero, `quotient`=all ones and `overflow`=1.
- Divide by zero: `quotient`=all ones, `remainder`=0, `div_by_zero`=1, `overflow`=0.
- `enable` in any state other than IDLE is ignored. There is no queueing and no abort.
- Operand inputs may change freely after the start cycle.

## Timing
- Reset (async assert, removal synchronous to `clk`): state IDLE; `quotient`, `remainder`, `busy`, `done`, `overflow`, `div_by_zero` all 0.
- Start accepted at edge k. `done` is high in the cycle after edge k+N_W+1, or k+N_W+2 with the macro.
- Divide-by-zero completes at edge k+1 with `done` high.
- Back-to-back starts: `enable` in the `done` cycle is ignored. The earliest accepted start is the first IDLE cycle after `done`.
- Reset during CALC/ROUND: the operation is lost, no `done` is produced, and the outputs go to their reset values.

## Configuration
- `SEQ_DIVIDER_ROUND_EN` defined: the ROUND state is added (one extra cycle). If 2·remainder ≥ divisor, the internal quotient is incremented before saturation; the increment can cause `overflow`. `remainder` still reports the truncated remainder.
- `SEQ_DIVIDER_ROUND_EN` undefined: the quotient is truncated and there is no ROUND state.

## Structure
- Package `divider_pkg`: state enum type, default width constants, and localparam for counter width $clog2(N_W+1).
- Sub-module `divider_step`: combinational single restoring step. Inputs are the partial remainder, the incoming bit and the divisor. Outputs are the next remainder and the quotient bit. It is instantiated once per cycle of iteration.

## Test plan
- N_W=16,D_W=16,Q_W=8: 765/63 → quotient 12, remainder 9, flags 0; `done` 17 cycles after the start edge (18 with macro, quotient still 12).
- 100/8 → macro off: quotient 12, remainder 4; macro on: quotient 13, remainder 4.
- 65535/1 → quotient 255, remainder 0, `overflow`=1; 255/1 → 255, `overflow`=0.
- 500/0 → `done` at start+1, quotient 255, remainder 0, `div_by_zero`=1.
- Start 765/63, pulse `enable` with 10/2 mid-CALC → result 12 r 9 only, single `done`; assert `reset_n`=0 mid-CALC on a second run → all outputs 0, no `done`.
- N_W=8,D_W=4,Q_W=8: 200/15 → 13 r 5; `done` 9 cycles after start.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared types and defaults for the sequential restoring divider.
//   state_t    - controller state encoding (IDLE, CALC, ROUND, DONE)
//   DEF_*      - default widths used when an instance does not override them
//   cnt_width  - bit counter width able to hold 0..n
// Configuration macro: SEQ_DIVIDER_ROUND_EN (consumed by seq_divider).
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_N_W   = 16;
  localparam int DEF_D_W   = 16;
  localparam int DEF_Q_W   = 8;
  localparam int DEF_CNT_W = $clog2(DEF_N_W + 1);

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division step.
// Ports:
//   part_rem [D_W-1:0] in  - partial remainder from the previous step (< divisor)
//   in_bit             in  - next dividend bit, entering at the LSB
//   divisor  [D_W-1:0] in  - divisor (non-zero whenever this step is used)
//   next_rem [D_W-1:0] out - partial remainder after this step
//   q_bit              out - quotient bit produced by this step
module divider_step #(
  parameter int D_W = 16
) (
  input  logic [D_W-1:0] part_rem,
  input  logic           in_bit,
  input  logic [D_W-1:0] divisor,
  output logic [D_W-1:0] next_rem,
  output logic           q_bit
);

  logic [D_W:0] shifted;
  logic [D_W:0] diff;

  // Shift in the dividend bit and trial-subtract; restore on borrow.
  always_comb begin
    shifted = {part_rem, in_bit};
    diff    = shifted - {1'b0, divisor};
    // part_rem < divisor keeps shifted < 2*divisor, so diff's MSB is
    // set exactly when the subtraction borrowed.
    if (diff[D_W]) begin
      q_bit    = 1'b0;
      next_rem = shifted[D_W-1:0];
    end else begin
      q_bit    = 1'b1;
      next_rem = diff[D_W-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one dividend bit per
// cycle, with saturating quotient, truncated remainder and status flags.
// Optional macro SEQ_DIVIDER_ROUND_EN adds a ROUND state that rounds the
// quotient to nearest (half up) before saturation.
// Ports:
//   clk, reset_n (async, active-low)
//   enable        in  - start request, honoured only when idle
//   g_dividend_Q  in  - dividend [N_W-1:0], captured on accepted start
//   g_divider_Q   in  - divisor  [D_W-1:0], captured on accepted start
//   quotient      out - result [Q_W-1:0], all ones on overflow / divide by zero
//   remainder     out - dividend mod divisor [D_W-1:0]
//   busy          out - operation in flight, through the done cycle
//   done          out - one-cycle completion pulse
//   overflow      out - true quotient did not fit in Q_W bits
//   div_by_zero   out - captured divisor was zero
module seq_divider
  import divider_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int D_W = DEF_D_W,
  parameter int Q_W = DEF_Q_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [N_W-1:0] g_dividend_Q,
  input  logic [D_W-1:0] g_divider_Q,
  output logic [Q_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           busy,
  output logic           done,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int CNT_W = cnt_width(N_W);

  state_t           state, state_next;
  logic             start;
  logic [N_W-1:0]   dvd;
  logic [D_W-1:0]   dvs;
  logic [D_W-1:0]   prem;
  logic [N_W:0]     quo;       // one spare bit so rounding can carry out
  logic [CNT_W-1:0] cnt;
  logic             dz;
  logic [D_W-1:0]   step_rem;
  logic             step_q;
  logic [Q_W-1:0]   res_q;
  logic [D_W-1:0]   res_r;
  logic             res_ovf;

  divider_step #(.D_W(D_W)) u_step (
    .part_rem (prem),
    .in_bit   (dvd[N_W-1]),
    .divisor  (dvs),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a start is refused during the done pulse so the
  // earliest restart is the first idle cycle after completion.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !done) begin
          start      = 1'b1;
          state_next = (g_divider_Q == '0) ? ST_DONE : ST_CALC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt == CNT_W'(N_W - 1)) begin
`ifdef SEQ_DIVIDER_ROUND_EN
          state_next = ST_ROUND;
`else
          state_next = ST_DONE;
`endif
        end else begin
          state_next = ST_CALC;
        end
      end
`ifdef SEQ_DIVIDER_ROUND_EN
      ST_ROUND: state_next = ST_DONE;
`endif
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd  <= '0;
      dvs  <= '0;
      prem <= '0;
      quo  <= '0;
      cnt  <= '0;
      dz   <= 1'b0;
    end else if (start) begin
      dvd  <= g_dividend_Q;
      dvs  <= g_divider_Q;
      prem <= '0;
      quo  <= '0;
      cnt  <= '0;
      dz   <= (g_divider_Q == '0);
    end else if (state == ST_CALC) begin
      dvd  <= dvd << 1;
      prem <= step_rem;
      quo  <= {quo[N_W-1:0], step_q};
      cnt  <= cnt + CNT_W'(1);
`ifdef SEQ_DIVIDER_ROUND_EN
    end else if (state == ST_ROUND) begin
      // Round half up: 2*remainder >= divisor.
      if ({prem, 1'b0} >= {1'b0, dvs}) begin
        quo <= quo + (N_W + 1)'(1);
      end else begin
        quo <= quo;
      end
`endif
    end else begin
      dvd <= dvd;
    end
  end

  // Final result selection: divide-by-zero, saturation, or plain quotient.
  always_comb begin
    res_q   = quo[Q_W-1:0];
    res_r   = prem;
    res_ovf = 1'b0;
    if (dz) begin
      res_q = '1;
      res_r = '0;
    end else if (|quo[N_W:Q_W]) begin
      res_q   = '1;
      res_ovf = 1'b1;
    end else begin
      res_q = quo[Q_W-1:0];
    end
  end

  // Registered outputs: loaded as DONE is left, held until the next completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= start || (state != ST_IDLE);
      if (state == ST_DONE) begin
        done        <= 1'b1;
        quotient    <= res_q;
        remainder   <= res_r;
        overflow    <= res_ovf;
        div_by_zero <= dz;
      end else begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a 16/16->8 instance checked every
// cycle against an arithmetic reference model, plus an 8/4->8 instance
// checked with literal expectations. Honours SEQ_DIVIDER_ROUND_EN.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int NA = 16, DA = 16, QA = 8;
  localparam int NB = 8,  DB = 4,  QB = 8;
  localparam int LAT_A = NA + 1 + RND;
  localparam int LAT_B = NB + 1 + RND;

  typedef struct {
    longint q;
    longint r;
    bit     ovf;
    bit     dz;
  } res_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          en_a, busy_a, done_a, ovf_a, dz_a;
  logic [NA-1:0] dvd_a;
  logic [DA-1:0] dvs_a, r_a;
  logic [QA-1:0] q_a;
  logic          en_b, busy_b, done_b, ovf_b, dz_b;
  logic [NB-1:0] dvd_b;
  logic [DB-1:0] dvs_b, r_b;
  logic [QB-1:0] q_b;

  seq_divider #(.N_W(NA), .D_W(DA), .Q_W(QA)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a),
    .g_dividend_Q(dvd_a), .g_divider_Q(dvs_a),
    .quotient(q_a), .remainder(r_a), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .div_by_zero(dz_a)
  );

  seq_divider #(.N_W(NB), .D_W(DB), .Q_W(QB)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b),
    .g_dividend_Q(dvd_b), .g_divider_Q(dvs_b),
    .quotient(q_b), .remainder(r_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .div_by_zero(dz_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference division straight from the arithmetic definition.
  function automatic res_t ref_div(input longint n, input longint d, input int qw);
    res_t   res;
    longint qt;
    longint lim;
    lim = longint'(1) << qw;
    if (d == 0) begin
      res.q = lim - 1; res.r = 0; res.ovf = 1'b0; res.dz = 1'b1;
    end else begin
      qt    = n / d;
      res.r = n % d;
      if (RND != 0 && 2 * res.r >= d) qt++;
      res.dz  = 1'b0;
      res.ovf = (qt >= lim);
      res.q   = res.ovf ? lim - 1 : qt;
    end
    return res;
  endfunction

  // Transaction-level model of instance A: accepted starts, completion time,
  // expected output values.
  int   cyc;
  bit   m_active;
  int   m_done_edge;
  res_t p_res, e_res;
  logic exp_done, exp_busy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc         <= 0;
      m_active    <= 1'b0;
      m_done_edge <= 0;
      exp_done    <= 1'b0;
      exp_busy    <= 1'b0;
      p_res       <= '{0, 0, 1'b0, 1'b0};
      e_res       <= '{0, 0, 1'b0, 1'b0};
    end else begin
      cyc      <= cyc + 1;
      exp_busy <= m_active || (!exp_done && en_a);
      if (m_active && cyc == m_done_edge) begin
        exp_done <= 1'b1;
        e_res    <= p_res;
        m_active <= 1'b0;
      end else begin
        exp_done <= 1'b0;
      end
      if (!m_active && !exp_done && en_a) begin
        m_active    <= 1'b1;
        p_res       <= ref_div(longint'(dvd_a), longint'(dvs_a), QA);
        m_done_edge <= cyc + ((dvs_a == '0) ? 1 : LAT_A);
      end
    end
  end

  // Cycle-by-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      check("done_a", done_a, exp_done);
      check("busy_a", busy_a, exp_busy);
      check("quot_a", q_a, e_res.q);
      check("rem_a",  r_a, e_res.r);
      check("ovf_a",  ovf_a, e_res.ovf);
      check("dz_a",   dz_a,  e_res.dz);
    end
  end

  task automatic start_a(input int n, input int d);
    en_a  = 1'b1;
    dvd_a = NA'(n);
    dvs_a = DA'(d);
    @(negedge clk);
    en_a  = 1'b0;
    dvd_a = NA'($urandom);
    dvs_a = DA'($urandom);
  endtask

  task automatic wait_done_a(output int lat);
    lat = 0;
    while (!done_a && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!done_a) check("timeout_a", done_a, 1'b1);
  endtask

  task automatic run_a(input int n, input int d, input int eq, input int er,
                       input bit eovf, input bit edz, input int elat);
    int lat;
    start_a(n, d);
    wait_done_a(lat);
    check("lit_lat_a", lat, elat);
    check("lit_q_a",   q_a, eq);
    check("lit_r_a",   r_a, er);
    check("lit_ovf_a", ovf_a, eovf);
    check("lit_dz_a",  dz_a, edz);
    @(negedge clk);
  endtask

  task automatic run_b(input int n, input int d, input int eq, input int er,
                       input bit eovf, input bit edz, input int elat);
    int lat;
    en_b  = 1'b1;
    dvd_b = NB'(n);
    dvs_b = DB'(d);
    @(negedge clk);
    en_b  = 1'b0;
    dvd_b = NB'($urandom);
    dvs_b = DB'($urandom);
    lat = 0;
    while (!done_b && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("lit_lat_b", lat, elat);
    check("lit_q_b",   q_b, eq);
    check("lit_r_b",   r_b, er);
    check("lit_ovf_b", ovf_b, eovf);
    check("lit_dz_b",  dz_b, edz);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nd;
    int n;
    int d;
    reset_n = 1'b0;
    en_a = 1'b0; dvd_a = '0; dvs_a = '0;
    en_b = 1'b0; dvd_b = '0; dvs_b = '0;
    repeat (3) @(negedge clk);
    check("rst_q_a",    q_a, 0);
    check("rst_flags_a", {busy_a, done_a, ovf_a, dz_a}, 0);
    check("rst_r_b",    r_b, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Literal expectations that pin the model.
    run_a(765, 63, 12, 9, 1'b0, 1'b0, LAT_A);
    run_a(100, 8, (RND != 0) ? 13 : 12, 4, 1'b0, 1'b0, LAT_A);
    run_a(65535, 1, 255, 0, 1'b1, 1'b0, LAT_A);
    run_a(255, 1, 255, 0, 1'b0, 1'b0, LAT_A);
    run_a(511, 2, 255, 1, (RND != 0), 1'b0, LAT_A);
    run_a(500, 0, 255, 0, 1'b0, 1'b1, 1);
    run_b(200, 15, 13, 5, 1'b0, 1'b0, LAT_B);
    run_b(255, 2, (RND != 0) ? 128 : 127, 1, 1'b0, 1'b0, LAT_B);
    run_b(255, 1, 255, 0, 1'b0, 1'b0, LAT_B);
    run_b(7, 0, 255, 0, 1'b0, 1'b1, 1);

    // Enable mid-CALC is ignored; enable in the done cycle is ignored.
    start_a(765, 63);
    repeat (5) @(negedge clk);
    en_a = 1'b1; dvd_a = 16'd10; dvs_a = 16'd2;
    @(negedge clk);
    en_a = 1'b0;
    wait_done_a(lat);
    check("mid_q_a", q_a, 12);
    check("mid_r_a", r_a, 9);
    en_a = 1'b1; dvd_a = 16'd10; dvs_a = 16'd2;
    @(negedge clk);
    en_a = 1'b0;
    check("done_cycle_start_ignored", busy_a, 1'b0);
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    check("no_extra_done", nd, 0);

    // Reset during CALC loses the operation.
    start_a(765, 63);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_q", q_a, 0);
    check("rst_mid_r", r_a, 0);
    check("rst_mid_flags", {busy_a, done_a, ovf_a, dz_a}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    check("rst_no_done", nd, 0);
    check("rst_hold_q", q_a, 0);

    // Randomized operations; the compare process checks every cycle.
    repeat (150) begin
      n = int'($urandom_range(0, 65535));
      d = int'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      if ($urandom_range(0, 7) == 0) d = int'($urandom_range(0, 3));
      start_a(n, d);
      wait_done_a(lat);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
